// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader. Receives a program as a byte stream, assembles
// little-endian 32-bit words and writes them into instruction memory. The CPU
// is held in reset until the whole image has been written.
//
// Stream format: one header byte with the word count N (1..MAX_WORDS),
// followed by 4*N data bytes. When IMEM_LOADER_CHECKSUM_EN is defined, one
// extra byte follows: the XOR of all data bytes (the header is not included).
//
// Configuration macro:
//   IMEM_LOADER_CHECKSUM_EN  enables the trailing checksum byte and CHECK state
//
// Ports:
//   clk         sole clock, all state updates on its rising edge
//   reset       synchronous, active-high reset
//   byte_valid  source presents byte_data
//   byte_data   serial program byte
//   byte_ready  loader accepts a byte this cycle
//   imem_we     one-cycle instruction memory write strobe
//   imem_addr   word-aligned byte address of the write
//   imem_wdata  instruction word being written
//   cpu_reset   holds the CPU in reset (released only once loading is done)
//   done        load completed successfully
//   error       load failed (bad header or checksum mismatch)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned MAX_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    // One extra bit so a count of exactly MAX_WORDS fits without wrapping.
    localparam int unsigned IDX_W = $clog2(MAX_WORDS) + 1;

    typedef enum logic [2:0] {
        ST_HEADER,
        ST_DATA,
        ST_DONE,
        ST_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        ST_CHECK
`endif
    } state_t;

    state_t             state_q,      state_d;
    logic [IDX_W-1:0]   count_q,      count_d;
    logic [IDX_W-1:0]   word_idx_q,   word_idx_d;
    logic [1:0]         byte_idx_q,   byte_idx_d;
    logic [23:0]        asm_q,        asm_d;
    logic               imem_we_q,    imem_we_d;
    logic [31:0]        imem_addr_q,  imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         checksum_q,   checksum_d;
`endif

    logic take;

    assign byte_ready = (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign take       = byte_valid && byte_ready;
    assign cpu_reset  = (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERROR);
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;

    // Next-state and datapath logic. Only the first three bytes of a word are
    // buffered; the fourth goes straight into the write-data register so the
    // write strobe appears the cycle after that byte is accepted.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif

        case (state_q)
            ST_HEADER: begin
                if (take) begin
                    if ((byte_data == 8'd0) || (32'(byte_data) > MAX_WORDS)) begin
                        state_d = ST_ERROR;
                    end else begin
                        count_d = IDX_W'(byte_data);
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                // All words written: this is the drain cycle in which the
                // last write strobe is on the bus, any byte offered is dropped.
                if (word_idx_q == count_q) begin
                    state_d = ST_DONE;
                end else if (take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum_d = checksum_q ^ byte_data;
`endif
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = byte_data;
                        2'd1: asm_d[15:8]  = byte_data;
                        2'd2: asm_d[23:16] = byte_data;
                        default: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = 32'({word_idx_q, 2'b00});
                            imem_wdata_d = {byte_data, asm_q};
                            word_idx_d   = word_idx_q + IDX_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                            if (word_idx_q == count_q - IDX_W'(1)) begin
                                state_d = ST_CHECK;
                            end
`endif
                        end
                    endcase
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (take) begin
                    state_d = (byte_data == checksum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif

            ST_DONE, ST_ERROR: begin
                state_d = state_q;
            end

            default: state_d = ST_HEADER;
        endcase
    end

    // State and datapath registers; reset wins over any byte offered in the
    // same cycle and discards a partially assembled word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HEADER;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed testbench for imem_loader. Inputs change on the falling edge and
// outputs are sampled on the falling edge; a monitor logs every write strobe
// into queues so the written image can be compared against expected words.
// Honours IMEM_LOADER_CHECKSUM_EN by appending the checksum byte to loads.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int errCount   = 0;
    int checkCount = 0;

    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];

    always #5 clk = ~clk;

    imem_loader #(.MAX_WORDS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    // Log every memory write seen by the bench.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wrAddrQ.push_back(imem_addr);
            wrDataQ.push_back(imem_wdata);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Present one byte (or an idle cycle) for the next rising edge.
    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        @(negedge clk);
        byte_valid = valid;
        byte_data  = data;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic doReset();
        wrAddrQ.delete();
        wrDataQ.delete();
        @(negedge clk);
        reset      = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        reset      = 1'b0;
    endtask

    // Cycle after the last data byte: send checksum when enabled, else idle.
    task automatic finishLoad(input logic [7:0] csum);
        @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_valid = 1'b1;
        byte_data  = csum;
`else
        byte_valid = 1'b0;
        byte_data  = csum;
`endif
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic [31:0] addr, input logic [31:0] data);
        if (idx < wrAddrQ.size()) begin
            checkOutput({tag, " addr"}, wrAddrQ[idx], addr);
            checkOutput({tag, " data"}, wrDataQ[idx], data);
        end
    endtask

    initial begin
        logic [7:0]  csum;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  seq8 [8];

        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // ---- reset state
        checkOutput("rst byte_ready", 32'(byte_ready), 32'd1);
        checkOutput("rst imem_we",    32'(imem_we),    32'd0);
        checkOutput("rst imem_addr",  imem_addr,       32'h0);
        checkOutput("rst imem_wdata", imem_wdata,      32'h0);
        checkOutput("rst cpu_reset",  32'(cpu_reset),  32'd1);
        checkOutput("rst done",       32'(done),       32'd0);
        checkOutput("rst error",      32'(error),      32'd0);

        // ---- single word, back-to-back, exact write/done timing
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'hB3);
        applyStimulus(1'b1, 8'h03);
        applyStimulus(1'b1, 8'h53);
        applyStimulus(1'b1, 8'h00);
        @(negedge clk);
        checkOutput("w1 we pulse",  32'(imem_we), 32'd1);
        checkOutput("w1 addr",      imem_addr,    32'h0);
        checkOutput("w1 data",      imem_wdata,   32'h005303B3);
        checkOutput("w1 not done",  32'(done),    32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_valid = 1'b1;
        byte_data  = 8'hE3;
`else
        byte_valid = 1'b0;
`endif
        @(negedge clk);
        byte_valid = 1'b0;
        checkOutput("w1 done",      32'(done),      32'd1);
        checkOutput("w1 cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("w1 error",     32'(error),     32'd0);
        checkOutput("w1 we low",    32'(imem_we),   32'd0);
        checkOutput("w1 data hold", imem_wdata,     32'h005303B3);
        idleCycles(2);
        checkOutput("w1 writes",    32'(wrAddrQ.size()), 32'd1);

        // ---- two words with byte_valid toggling
        doReset();
        seq8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        applyStimulus(1'b1, 8'h02);
        applyStimulus(1'b0, 8'hEE);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, seq8[i]);
            if (i != 7) applyStimulus(1'b0, 8'hEE);
        end
        finishLoad(8'h88);
        idleCycles(2);
        checkOutput("w2 writes", 32'(wrAddrQ.size()), 32'd2);
        checkWrite("w2 word0", 0, 32'h0, 32'h44332211);
        checkWrite("w2 word1", 1, 32'h4, 32'h88776655);
        checkOutput("w2 done", 32'(done), 32'd1);

        // ---- header 0 and header MAX_WORDS+1 both fail
        for (int h = 0; h < 2; h++) begin
            doReset();
            applyStimulus(1'b1, (h == 0) ? 8'h00 : 8'h21);
            idleCycles(2);
            checkOutput($sformatf("hdr%0d error", h),      32'(error),      32'd1);
            checkOutput($sformatf("hdr%0d byte_ready", h), 32'(byte_ready), 32'd0);
            checkOutput($sformatf("hdr%0d cpu_reset", h),  32'(cpu_reset),  32'd1);
            checkOutput($sformatf("hdr%0d done", h),       32'(done),       32'd0);
            applyStimulus(1'b1, 8'h01);
            applyStimulus(1'b1, 8'h01);
            idleCycles(2);
            checkOutput($sformatf("hdr%0d stuck", h),  32'(error),            32'd1);
            checkOutput($sformatf("hdr%0d writes", h), 32'(wrAddrQ.size()),   32'd0);
        end

        // ---- full depth: 32 words
        doReset();
        csum = 8'h00;
        applyStimulus(1'b1, 8'h20);
        for (int w = 0; w < 32; w++) begin
            b0 = 8'(w);
            b1 = 8'(w) ^ 8'hA5;
            applyStimulus(1'b1, b0);
            applyStimulus(1'b1, b1);
            applyStimulus(1'b1, 8'h5A);
            applyStimulus(1'b1, 8'hC3);
            csum = csum ^ b0 ^ b1 ^ 8'h5A ^ 8'hC3;
        end
        finishLoad(csum);
        checkOutput("full done", 32'(done), 32'd1);
        checkOutput("full writes", 32'(wrAddrQ.size()), 32'd32);
        for (int w = 0; w < 32; w++) begin
            b0 = 8'(w);
            b1 = 8'(w) ^ 8'hA5;
            checkWrite($sformatf("full word%0d", w), w, 32'(w * 4), {8'hC3, 8'h5A, b1, b0});
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'hFF);
        idleCycles(2);
        checkOutput("full extra ignored", 32'(wrAddrQ.size()), 32'd32);
        checkOutput("full last addr",     imem_addr,           32'h7C);
        checkOutput("full byte_ready",    32'(byte_ready),     32'd0);

        // ---- reset mid-load, colliding with a byte, then clean reload
        doReset();
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'hAA);
        applyStimulus(1'b1, 8'hBB);
        @(negedge clk);
        reset      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hCC;
        @(negedge clk);
        reset      = 1'b0;
        byte_valid = 1'b0;
        checkOutput("abort we",     32'(imem_we),    32'd0);
        checkOutput("abort addr",   imem_addr,       32'h0);
        checkOutput("abort wdata",  imem_wdata,      32'h0);
        checkOutput("abort ready",  32'(byte_ready), 32'd1);
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h13);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h00);
        finishLoad(8'h13);
        idleCycles(2);
        checkOutput("reload writes", 32'(wrAddrQ.size()), 32'd1);
        checkWrite("reload word0", 0, 32'h0, 32'h00000013);
        checkOutput("reload done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---- bad checksum
        doReset();
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'hB3);
        applyStimulus(1'b1, 8'h03);
        applyStimulus(1'b1, 8'h53);
        applyStimulus(1'b1, 8'h00);
        finishLoad(8'h00);
        checkOutput("csum error",     32'(error),     32'd1);
        checkOutput("csum cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("csum done",      32'(done),      32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
